// File: rtl/fetch_pkt_sequencer.sv
// fetch_pkt_sequencer
//   Takes 4-lane fetch packets with an arbitrary lane-valid mask, packs the
//   valid lanes in lane order, and feeds them to a 2-wide FIFO write port over
//   one or two beats. Handles front-end flush and FIFO back-pressure.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   flush_i               front-end flush (same cycle as the FIFO flush)
//   pkt_valid_i/ready_o   fetch packet handshake
//   pkt_mask_i            lane-valid mask, bit i qualifies lane i
//   pkt_data_i            packet lanes, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fifo_write_valid_o    FIFO write request
//   fifo_write_ready_i    FIFO can take a beat
//   fifo_write_num_o      lanes in this beat (0..2)
//   fifo_write_data_o     beat lanes, lane 0 = older instruction
//   busy_o                lanes still pending
module fetch_pkt_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int PKT_LANES  = 4,
  parameter int WR_LANES   = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush_i,
  input  logic                            pkt_valid_i,
  output logic                            pkt_ready_o,
  input  logic [PKT_LANES-1:0]            pkt_mask_i,
  input  logic [PKT_LANES*DATA_WIDTH-1:0] pkt_data_i,
  output logic                            fifo_write_valid_o,
  input  logic                            fifo_write_ready_i,
  output logic [1:0]                      fifo_write_num_o,
  output logic [WR_LANES*DATA_WIDTH-1:0]  fifo_write_data_o,
  output logic                            busy_o
);

  logic [DATA_WIDTH-1:0] buf_q [PKT_LANES];
  logic [2:0]            rem_q;
  logic [1:0]            rd_q;

  logic [DATA_WIDTH-1:0] comp [PKT_LANES];
  logic [2:0]            n_valid;
  logic                  fire;
  logic                  accept;

  // Pack the valid lanes toward lane 0, preserving lane order.
  always_comb begin
    n_valid = '0;
    for (int i = 0; i < PKT_LANES; i++) comp[i] = '0;
    for (int i = 0; i < PKT_LANES; i++) begin
      if (pkt_mask_i[i]) begin
        comp[n_valid[1:0]] = pkt_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        n_valid = n_valid + 3'd1;
      end
    end
  end

  assign fifo_write_valid_o = (rem_q != 3'd0) & ~flush_i;
  assign fifo_write_num_o   = !fifo_write_valid_o ? 2'd0 :
                              (rem_q >= 3'd2)     ? 2'd2 : rem_q[1:0];

  // rd_q is only ever 0 or 2, so its upper bit selects the lane pair.
  assign fifo_write_data_o  = rd_q[1] ? {buf_q[3], buf_q[2]} : {buf_q[1], buf_q[0]};

  assign fire   = fifo_write_valid_o & fifo_write_ready_i;
  // Accept while draining the last beat so back-to-back packets have no bubble.
  assign pkt_ready_o = ~flush_i & ((rem_q == 3'd0) | (fire & (rem_q <= 3'd2)));
  assign accept = pkt_valid_i & pkt_ready_o;
  assign busy_o = (rem_q != 3'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q <= '0;
      rd_q  <= '0;
    end else if (flush_i) begin
      rem_q <= '0;
      rd_q  <= '0;
    end else if (accept) begin
      // A new packet overrides the state left by a simultaneous final beat.
      rem_q <= n_valid;
      rd_q  <= '0;
    end else if (fire) begin
      rem_q <= rem_q - {1'b0, fifo_write_num_o};
      rd_q  <= rd_q + 2'd2;
    end
  end

  // Lane storage needs no reset: it is only read while rem_q is non-zero.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < PKT_LANES; i++) buf_q[i] <= comp[i];
    end
  end

  a_rem_range: assert property (@(posedge clk) disable iff (!rst_n)
    rem_q <= 3'd4);
  a_rd_rem_sum: assert property (@(posedge clk) disable iff (!rst_n)
    ({2'b00, rd_q} + {1'b0, rem_q}) <= 4'd4);
  a_no_empty_fire: assert property (@(posedge clk) disable iff (!rst_n)
    !(fire && rem_q == 3'd0));

endmodule

// File: tb/tb_fetch_pkt_sequencer.sv
// Testbench for fetch_pkt_sequencer: directed scenarios followed by random
// traffic, all checked against a queue-based model of pending lanes.
module tb_fetch_pkt_sequencer;

  localparam int DW = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           flush_i;
  logic           pkt_valid_i;
  logic           pkt_ready_o;
  logic [3:0]     pkt_mask_i;
  logic [4*DW-1:0] pkt_data_i;
  logic           fifo_write_valid_o;
  logic           fifo_write_ready_i;
  logic [1:0]     fifo_write_num_o;
  logic [2*DW-1:0] fifo_write_data_o;
  logic           busy_o;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] pend [$];

  always #5 clk = ~clk;

  fetch_pkt_sequencer #(.DATA_WIDTH(DW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .flush_i            (flush_i),
    .pkt_valid_i        (pkt_valid_i),
    .pkt_ready_o        (pkt_ready_o),
    .pkt_mask_i         (pkt_mask_i),
    .pkt_data_i         (pkt_data_i),
    .fifo_write_valid_o (fifo_write_valid_o),
    .fifo_write_ready_i (fifo_write_ready_i),
    .fifo_write_num_o   (fifo_write_num_o),
    .fifo_write_data_o  (fifo_write_data_o),
    .busy_o             (busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs after the falling edge, check outputs against the
  // model, then advance the model across the rising edge.
  task automatic step(input logic rst, input logic pv, input logic [3:0] mask,
                      input logic [4*DW-1:0] data, input logic wr, input logic fl);
    int  sz;
    bit  e_valid, e_fire, e_ready;
    int  e_num;
    rst_n = rst; pkt_valid_i = pv; pkt_mask_i = mask; pkt_data_i = data;
    fifo_write_ready_i = wr; flush_i = fl;
    #1;
    sz      = pend.size();
    e_valid = (sz != 0) && !fl;
    e_num   = !e_valid ? 0 : (sz >= 2 ? 2 : sz);
    e_fire  = e_valid && wr;
    e_ready = !fl && (sz == 0 || (e_fire && sz <= 2));
    if (rst) begin
      chk("valid", 64'(fifo_write_valid_o), 64'(e_valid));
      chk("num",   64'(fifo_write_num_o),   64'(e_num));
      chk("ready", 64'(pkt_ready_o),        64'(e_ready));
      chk("busy",  64'(busy_o),             64'(sz != 0));
      if (e_num >= 1) chk("lane0", 64'(fifo_write_data_o[DW-1:0]), 64'(pend[0]));
      if (e_num == 2) chk("lane1", 64'(fifo_write_data_o[2*DW-1:DW]), 64'(pend[1]));
    end
    @(posedge clk);
    if (!rst || fl) pend.delete();
    else if (pv && e_ready) begin
      pend.delete();
      for (int i = 0; i < 4; i++) if (mask[i]) pend.push_back(data[i*DW +: DW]);
    end else if (e_fire) begin
      repeat (e_num) void'(pend.pop_front());
    end
    @(negedge clk);
  endtask

  function automatic logic [4*DW-1:0] rnd_pkt();
    logic [4*DW-1:0] p;
    for (int i = 0; i < 4; i++) p[i*DW +: DW] = $urandom;
    return p;
  endfunction

  localparam logic [4*DW-1:0] ABCD = {32'hD0D0_000D, 32'hC0C0_000C, 32'hB0B0_000B, 32'hA0A0_000A};
  logic [4*DW-1:0] p1, p2, p3;

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; pkt_valid_i = 1'b0; pkt_mask_i = '0;
    pkt_data_i = '0; fifo_write_ready_i = 1'b1;
    @(negedge clk);
    step(0, 0, 4'h0, '0, 1, 0);
    step(0, 0, 4'h0, '0, 1, 0);
    step(1, 0, 4'h0, '0, 1, 0);                    // reset state

    // Full packet, two beats, then idle.
    step(1, 1, 4'b1111, ABCD, 1, 0);
    chk("plan_first_lane0", 64'(fifo_write_data_o[DW-1:0]), 64'h0000_0000_A0A0_000A);
    step(1, 0, 4'h0, '0, 1, 0);
    step(1, 0, 4'h0, '0, 1, 0);
    step(1, 0, 4'h0, '0, 1, 0);

    // Sparse masks.
    step(1, 1, 4'b1010, ABCD, 1, 0);
    step(1, 1, 4'b0100, ABCD, 1, 0);
    step(1, 0, 4'h0, '0, 1, 0);
    step(1, 0, 4'h0, '0, 1, 0);

    // Empty mask is consumed with no write.
    step(1, 1, 4'b0000, ABCD, 1, 0);
    step(1, 0, 4'h0, '0, 1, 0);

    // Back-pressure for three cycles, then release.
    step(1, 1, 4'b1111, ABCD, 1, 0);
    repeat (3) step(1, 0, 4'h0, '0, 0, 0);
    repeat (3) step(1, 0, 4'h0, '0, 1, 0);

    // Three 4-lane packets streamed back to back.
    p1 = rnd_pkt(); p2 = rnd_pkt(); p3 = rnd_pkt();
    step(1, 1, 4'b1111, p1, 1, 0);
    step(1, 1, 4'b1111, p2, 1, 0);
    step(1, 1, 4'b1111, p2, 1, 0);
    step(1, 1, 4'b1111, p3, 1, 0);
    step(1, 1, 4'b1111, p3, 1, 0);
    repeat (3) step(1, 0, 4'h0, '0, 1, 0);

    // Flush after the first beat of a 3-lane packet.
    step(1, 1, 4'b1110, ABCD, 1, 0);
    step(1, 0, 4'h0, '0, 1, 0);
    step(1, 0, 4'h0, '0, 1, 1);
    step(1, 0, 4'h0, '0, 1, 0);

    // Flush while a beat is stalled, then reset mid-packet.
    step(1, 1, 4'b1111, ABCD, 0, 0);
    step(1, 1, 4'b1111, ABCD, 0, 1);
    step(1, 1, 4'b1011, ABCD, 1, 0);
    step(0, 0, 4'h0, '0, 1, 0);
    step(1, 0, 4'h0, '0, 1, 0);

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 3) != 0),
           4'($urandom),
           rnd_pkt(),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 24) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
